seq_detector_param: RTL

- Parametrised serial bit-pattern detector. It is the successor to the fixed 5-bit Mealy overlap detector.
- Pattern length is set by a parameter. The pattern value is runtime-loadable.
- Overlap or non-overlap matching is selected at runtime.
- Adds a sample-valid qualifier and a saturating match counter.
- Sits on a serial data stream and flags each completed occurrence of the pattern with a one-cycle registered pulse.

---
 rtl/seq_detector_param.sv | 105 ++++++++++
 1 files changed

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector: runtime pattern, overlap select,
// valid qualifier, saturating match counter. Optional mask: SEQ_DET_MASK_EN.
// Ports: clk, rst (sync, active-high), data_in, data_valid, overlap_en,
//   cfg_load, cfg_pattern[LEN], clear_count, [cfg_mask[LEN]],
//   data_out (registered pulse), match_count[CNT_W].
module seq_detector_param #(
  parameter int               LEN     = 5,
  parameter logic [LEN-1:0]   PATTERN = 5'b11010,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic             data_valid,
  input  logic             overlap_en,
  input  logic             cfg_load,
  input  logic [LEN-1:0]   cfg_pattern,
  input  logic             clear_count,
`ifdef SEQ_DET_MASK_EN
  input  logic [LEN-1:0]   cfg_mask,
`endif
  output logic             data_out,
  output logic [CNT_W-1:0] match_count
);

  localparam int FW = $clog2(LEN + 1);
  localparam logic [FW-1:0]    FILL_MAX = FW'(LEN);
  localparam logic [FW-1:0]    FILL_THR = FW'(LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [LEN-1:0]   r_pat;
  logic [LEN-1:0]   r_hist;
  logic [FW-1:0]    r_fill;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out;

  logic             w_accept;
  logic [LEN-1:0]   w_hist_next;
  logic [LEN-1:0]   w_mask;
  logic             w_full;
  logic             w_match;

`ifdef SEQ_DET_MASK_EN
  logic [LEN-1:0]   r_mask;
  assign w_mask = r_mask;
`else
  assign w_mask = {LEN{1'b1}};
`endif

  // A sample arriving with cfg_load is dropped outright.
  assign w_accept    = data_valid & ~cfg_load;
  assign w_hist_next = {r_hist[LEN-2:0], data_in};
  // fill+1 >= LEN, i.e. this sample completes a full window
  assign w_full      = (r_fill >= FILL_THR);
  assign w_match     = w_accept & w_full &
                       ((w_hist_next & w_mask) == (r_pat & w_mask));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat  <= PATTERN;
      r_hist <= '0;
      r_fill <= '0;
      r_out  <= 1'b0;
    end else begin
      r_out <= w_match;
      if (cfg_load) begin
        r_pat  <= cfg_pattern;
        r_hist <= '0;
        r_fill <= '0;
      end else if (data_valid) begin
        if (w_match && !overlap_en) begin
          r_hist <= '0;
          r_fill <= '0;
        end else begin
          r_hist <= w_hist_next;
          if (r_fill != FILL_MAX)
            r_fill <= r_fill + FW'(1);
        end
      end
    end
  end

`ifdef SEQ_DET_MASK_EN
  always_ff @(posedge clk) begin
    if (rst)
      r_mask <= {LEN{1'b1}};
    else if (cfg_load)
      r_mask <= cfg_mask;
  end
`endif

  // Clear wins over the old value but not over a same-cycle match.
  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (clear_count)
      r_cnt <= w_match ? CNT_W'(1) : '0;
    else if (w_match && r_cnt != CNT_MAX)
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign data_out    = r_out;
  assign match_count = r_cnt;

endmodule
